// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes seen by the ALU control decoder and
// the execute stage, default datapath widths, and a small code classifier.
package alu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_ADDU = 4'b1010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SUBU = 4'b1110;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;

  // Only the signed add/sub codes can raise an overflow.
  function automatic logic is_ovf_checked(input logic [3:0] code);
    return (code == ALU_ADD) || (code == ALU_SUB);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX/MEM bundle of the execute stage. The master side drives the
// decoded instruction and pipeline controls; the slave side (ex_stage)
// returns the EX/MEM register contents.
interface ex_stage_if
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
);
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] store_data;
  logic [REG_W-1:0]  dest_reg;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic              mem_to_reg;

  logic              out_valid;
  logic [DATA_W-1:0] alu_result;
  logic              zero;
  logic              ovf_exc;
  logic [DATA_W-1:0] store_data_out;
  logic [REG_W-1:0]  dest_reg_out;
  logic              reg_write_out;
  logic              mem_read_out;
  logic              mem_write_out;
  logic              mem_to_reg_out;

  modport master (
    output stall, flush, in_valid, alu_ctrl, op_a, op_b, shamt, store_data,
           dest_reg, reg_write, mem_read, mem_write, mem_to_reg,
    input  out_valid, alu_result, zero, ovf_exc, store_data_out, dest_reg_out,
           reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out
  );

  modport slave (
    input  stall, flush, in_valid, alu_ctrl, op_a, op_b, shamt, store_data,
           dest_reg, reg_write, mem_read, mem_write, mem_to_reg,
    output out_valid, alu_result, zero, ovf_exc, store_data_out, dest_reg_out,
           reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out
  );
endinterface

// File: rtl/ex_stage_alu_core.sv
// Combinational ALU of the execute stage: result, zero flag and signed
// overflow. Overflow detection exists only when EX_OVF_TRAP_EN is defined;
// otherwise ovf_o is tied low.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [3:0]        alu_ctrl_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  input  logic [4:0]        shamt_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              ovf_o
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;

  assign a_s = op_a_i;
  assign b_s = op_b_i;

  // Result selection; unknown codes produce 0.
  always_comb begin
    result_o = '0;
    case (alu_ctrl_i)
      ALU_ADD, ALU_ADDU: result_o = op_a_i + op_b_i;
      ALU_SUB, ALU_SUBU: result_o = op_a_i - op_b_i;
      ALU_AND:           result_o = op_a_i & op_b_i;
      ALU_OR:            result_o = op_a_i | op_b_i;
      ALU_XOR:           result_o = op_a_i ^ op_b_i;
      ALU_NOR:           result_o = ~(op_a_i | op_b_i);
      ALU_SLT:           result_o[0] = (a_s < b_s);
      ALU_SLL:           result_o = op_b_i << shamt_i;
      ALU_SRL:           result_o = op_b_i >> shamt_i;
      default:           result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

`ifdef EX_OVF_TRAP_EN
  // Sign-rule overflow: add flips sign of like-signed operands, sub flips
  // sign of op_a when operands differ in sign.
  always_comb begin
    ovf_o = 1'b0;
    if (is_ovf_checked(alu_ctrl_i)) begin
      if (alu_ctrl_i == ALU_ADD)
        ovf_o = (op_a_i[DATA_W-1] == op_b_i[DATA_W-1]) &&
                (result_o[DATA_W-1] != op_a_i[DATA_W-1]);
      else
        ovf_o = (op_a_i[DATA_W-1] != op_b_i[DATA_W-1]) &&
                (result_o[DATA_W-1] != op_a_i[DATA_W-1]);
    end
  end
`else
  assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU plus the EX/MEM pipeline register with flush > stall >
// capture priority. Optional overflow trap under macro EX_OVF_TRAP_EN: a
// valid overflowing add/sub raises ovf_exc and suppresses reg_write_out.
module ex_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  ex_stage_if.slave bus
);

  logic [DATA_W-1:0] core_result;
  logic              core_zero;
  logic              core_ovf;

  alu_core #(.DATA_W(DATA_W)) u_alu_core (
    .alu_ctrl_i (bus.alu_ctrl),
    .op_a_i     (bus.op_a),
    .op_b_i     (bus.op_b),
    .shamt_i    (bus.shamt),
    .result_o   (core_result),
    .zero_o     (core_zero),
    .ovf_o      (core_ovf)
  );

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic [REG_W-1:0]  dest_q, dest_d;
  logic              rw_q, rw_d;
  logic              mr_q, mr_d;
  logic              mw_q, mw_d;
  logic              m2r_q, m2r_d;

  // Next EX/MEM contents: bubble on flush or empty slot, hold on stall.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    sdata_d  = sdata_q;
    dest_d   = dest_q;
    rw_d     = rw_q;
    mr_d     = mr_q;
    mw_d     = mw_q;
    m2r_d    = m2r_q;
    if (bus.flush || (!bus.stall && !bus.in_valid)) begin
      valid_d  = 1'b0;
      result_d = '0;
      zero_d   = 1'b0;
      ovf_d    = 1'b0;
      sdata_d  = '0;
      dest_d   = '0;
      rw_d     = 1'b0;
      mr_d     = 1'b0;
      mw_d     = 1'b0;
      m2r_d    = 1'b0;
    end else if (!bus.stall) begin
      valid_d  = 1'b1;
      result_d = core_result;
      zero_d   = core_zero;
      ovf_d    = core_ovf;
      sdata_d  = bus.store_data;
      dest_d   = bus.dest_reg;
      rw_d     = bus.reg_write & ~core_ovf;
      mr_d     = bus.mem_read;
      mw_d     = bus.mem_write;
      m2r_d    = bus.mem_to_reg;
    end
  end

  // EX/MEM register; reset empties the stage, discarding any held instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      sdata_q  <= '0;
      dest_q   <= '0;
      rw_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      m2r_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      sdata_q  <= sdata_d;
      dest_q   <= dest_d;
      rw_q     <= rw_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
      m2r_q    <= m2r_d;
    end
  end

  assign bus.out_valid      = valid_q;
  assign bus.alu_result     = result_q;
  assign bus.zero           = zero_q;
  assign bus.ovf_exc        = ovf_q;
  assign bus.store_data_out = sdata_q;
  assign bus.dest_reg_out   = dest_q;
  assign bus.reg_write_out  = rw_q;
  assign bus.mem_read_out   = mr_q;
  assign bus.mem_write_out  = mw_q;
  assign bus.mem_to_reg_out = m2r_q;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed cases followed by randomized traffic,
// checked against an arithmetic reference model of the EX/MEM register.
module tb_ex_stage;
  import alu_pkg::*;

`ifdef EX_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   ncmp;
  int   nfail;

  ex_stage_if #(.DATA_W(32), .REG_W(5)) bus ();

  ex_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Expected EX/MEM contents
  logic        m_valid, m_zero, m_ovf, m_rw, m_mr, m_mw, m_m2r;
  logic [31:0] m_res, m_sd;
  logic [4:0]  m_dr;

  function automatic void ref_alu(input logic [3:0] c, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] sh,
                                  output logic [31:0] r, output bit ov);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ub = longint'(b);
    longint p  = 64'd1 << sh;
    longint w;
    ov = 1'b0;
    r  = 32'd0;
    case (c)
      4'b0010: begin
        w = sa + sb; r = w[31:0];
        ov = (w > 64'sd2147483647) || (w < -64'sd2147483648);
      end
      4'b1010: r = a + b;
      4'b0110: begin
        w = sa - sb; r = w[31:0];
        ov = (w > 64'sd2147483647) || (w < -64'sd2147483648);
      end
      4'b1110: r = a - b;
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0101: r = a ^ b;
      4'b1100: r = ~(a | b);
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1111: begin w = ub * p; r = w[31:0]; end
      4'b1000: begin w = ub / p; r = w[31:0]; end
      default: r = 32'd0;
    endcase
  endfunction

  task automatic model_clear();
    m_valid = 0; m_res = 0; m_zero = 0; m_ovf = 0; m_sd = 0; m_dr = 0;
    m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0;
  endtask

  task automatic model_edge();
    logic [31:0] r;
    bit ov;
    if (!rst_n || bus.flush || (!bus.stall && !bus.in_valid)) begin
      model_clear();
    end else if (!bus.stall) begin
      ref_alu(bus.alu_ctrl, bus.op_a, bus.op_b, bus.shamt, r, ov);
      m_valid = 1;
      m_res   = r;
      m_zero  = (r == 32'd0);
      m_ovf   = TRAP && ov;
      m_sd    = bus.store_data;
      m_dr    = bus.dest_reg;
      m_rw    = bus.reg_write && !(TRAP && ov);
      m_mr    = bus.mem_read;
      m_mw    = bus.mem_write;
      m_m2r   = bus.mem_to_reg;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
    chk({tag, ".alu_result"}, bus.alu_result, m_res);
    chk({tag, ".zero"}, 32'(bus.zero), 32'(m_zero));
    chk({tag, ".ovf_exc"}, 32'(bus.ovf_exc), 32'(m_ovf));
    chk({tag, ".store_data_out"}, bus.store_data_out, m_sd);
    chk({tag, ".dest_reg_out"}, 32'(bus.dest_reg_out), 32'(m_dr));
    chk({tag, ".reg_write_out"}, 32'(bus.reg_write_out), 32'(m_rw));
    chk({tag, ".mem_read_out"}, 32'(bus.mem_read_out), 32'(m_mr));
    chk({tag, ".mem_write_out"}, 32'(bus.mem_write_out), 32'(m_mw));
    chk({tag, ".mem_to_reg_out"}, 32'(bus.mem_to_reg_out), 32'(m_m2r));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic v, input logic rw,
                       input logic mw);
    bus.alu_ctrl   = c;
    bus.op_a       = a;
    bus.op_b       = b;
    bus.shamt      = sh;
    bus.in_valid   = v;
    bus.reg_write  = rw;
    bus.mem_write  = mw;
    bus.mem_read   = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.store_data = $urandom;
    bus.dest_reg   = 5'($urandom);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_random();
    logic [3:0] codes [13];
    codes = '{ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU, ALU_AND, ALU_OR, ALU_XOR,
              ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, 4'b0011, 4'b1001};
    bus.alu_ctrl   = codes[$urandom_range(0, 12)];
    bus.op_a       = rnd_op();
    bus.op_b       = rnd_op();
    bus.shamt      = 5'($urandom);
    bus.in_valid   = ($urandom_range(0, 5) != 0);
    bus.reg_write  = 1'($urandom);
    bus.mem_read   = 1'($urandom);
    bus.mem_write  = 1'($urandom);
    bus.mem_to_reg = 1'($urandom);
    bus.store_data = $urandom;
    bus.dest_reg   = 5'($urandom);
  endtask

  initial begin
    ncmp  = 0;
    nfail = 0;
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    model_clear();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    rst_n = 1'b1;

    drive(ALU_ADD, 32'd5, 32'd3, 5'd0, 1'b1, 1'b1, 1'b0);
    step("add");
    chk("add_result", bus.alu_result, 32'h8);
    chk("add_zero", 32'(bus.zero), 32'd0);

    drive(ALU_SUB, 32'd7, 32'd7, 5'd0, 1'b1, 1'b1, 1'b0);
    step("sub");
    chk("sub_result", bus.alu_result, 32'h0);
    chk("sub_zero", 32'(bus.zero), 32'd1);

    drive(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b1, 1'b1, 1'b0);
    step("slt");
    chk("slt_result", bus.alu_result, 32'h1);

    drive(ALU_SLL, 32'd0, 32'd1, 5'd31, 1'b1, 1'b1, 1'b0);
    step("sll");
    chk("sll_result", bus.alu_result, 32'h8000_0000);

    drive(ALU_SRL, 32'd0, 32'h8000_0000, 5'd4, 1'b1, 1'b1, 1'b0);
    step("srl");
    chk("srl_result", bus.alu_result, 32'h0800_0000);

    drive(ALU_SLL, 32'd0, 32'h1234_5678, 5'd0, 1'b1, 1'b1, 1'b0);
    step("sll0");
    chk("sll0_result", bus.alu_result, 32'h1234_5678);

    drive(4'b0011, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b1, 1'b1, 1'b0);
    step("illegal");
    chk("illegal_result", bus.alu_result, 32'h0);
    chk("illegal_zero", 32'(bus.zero), 32'd1);
    chk("illegal_ovf", 32'(bus.ovf_exc), 32'd0);

    drive(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b1, 1'b1, 1'b0);
    step("add_ovf");
    chk("add_ovf_result", bus.alu_result, 32'h8000_0000);
    chk("add_ovf_exc", 32'(bus.ovf_exc), 32'(TRAP));
    chk("add_ovf_rw", 32'(bus.reg_write_out), 32'(!TRAP));
    chk("add_ovf_valid", 32'(bus.out_valid), 32'd1);

    drive(ALU_ADDU, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b1, 1'b1, 1'b0);
    step("addu");
    chk("addu_exc", 32'(bus.ovf_exc), 32'd0);
    chk("addu_rw", 32'(bus.reg_write_out), 32'd1);

    drive(ALU_SUB, 32'h8000_0000, 32'd1, 5'd0, 1'b1, 1'b1, 1'b0);
    step("sub_ovf");
    chk("sub_ovf_exc", 32'(bus.ovf_exc), 32'(TRAP));

    // stall holds everything for three cycles while inputs change
    drive(ALU_ADD, 32'd10, 32'd20, 5'd0, 1'b1, 1'b1, 1'b0);
    step("stall_cap");
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      step("stall");
      chk("stall_hold", bus.alu_result, 32'd30);
    end
    bus.stall = 1'b0;
    drive(ALU_ADD, 32'd1, 32'd2, 5'd0, 1'b1, 1'b1, 1'b0);
    step("unstall");
    chk("unstall_result", bus.alu_result, 32'd3);

    // flush beats stall with a valid store in EX/MEM
    drive(ALU_ADD, 32'd100, 32'd4, 5'd0, 1'b1, 1'b0, 1'b1);
    step("sw");
    chk("sw_mw", 32'(bus.mem_write_out), 32'd1);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    step("flush");
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_mw", 32'(bus.mem_write_out), 32'd0);
    chk("flush_result", bus.alu_result, 32'd0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    // asynchronous reset while a stalled store is held
    drive(ALU_ADD, 32'd64, 32'd8, 5'd0, 1'b1, 1'b0, 1'b1);
    step("pre_rst");
    bus.stall = 1'b1;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_model("async_rst");
    step("rst_hold");
    bus.stall = 1'b0;
    step("rst_hold2");
    rst_n = 1'b1;
    drive(ALU_ADD, 32'd5, 32'd3, 5'd0, 1'b1, 1'b1, 1'b0);
    step("post_rst");
    chk("post_rst_result", bus.alu_result, 32'd8);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive_random();
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
